// File: rtl/mc_datapath_if.sv
// Memory-side bus of mc_datapath: instruction fetch and data access, each a req/ready pair.
// The datapath uses the master modport; a memory model or arbiter uses the slave modport.
interface mc_datapath_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [31:0]     imem_rdata;
   logic            imem_ready;
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            dmem_ready;

   modport master (
      output imem_req, imem_addr,
      input  imem_rdata, imem_ready,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rdata, imem_ready,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ready
   );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle RV32I-subset datapath driven by an external decoder fed from ir.
// Define DP_PERF_CNT_EN to add the 64-bit cycle_cnt and instret_cnt counters.
module mc_datapath #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              NREGS    = 32
) (
   input  logic                clk,
   input  logic                rst,
   mc_datapath_if.master       bus,
   output logic [31:0]         ir,
   input  logic                pc_src,
   input  logic                alu_src,
   input  logic                mem_write,
   input  logic                reg_write,
   input  logic                is_load,
   input  logic                is_utype,
   input  logic                is_lui,
   input  logic [1:0]          result_src,
   input  logic [2:0]          alu_ctrl,
   input  logic [2:0]          imm_src,
   output logic                zero,
   output logic                retire,
   output logic [2:0]          state
`ifdef DP_PERF_CNT_EN
   ,
   output logic [63:0]         cycle_cnt,
   output logic [63:0]         instret_cnt
`endif
);

   localparam int NR = (NREGS > 32) ? 32 : NREGS;

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXEC    = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_MEMDONE = 3'd5
   } state_t;

   state_t          cur, nxt;
   logic [XLEN-1:0] pc, pc_next, a, b, imm, alu_q, mdr;
   logic [XLEN-1:0] rf [32];

   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rf_a, rf_b;
   logic [31:0]     imm32;
   logic [XLEN-1:0] imm_ext, src_b, alu_res, u_res, wb_res, pc_plus4;
   logic            imem_req_c, dmem_req_c;
   logic            unused_ctrl;

   assign unused_ctrl = is_utype;

   assign rs1      = ir[19:15];
   assign rs2      = ir[24:20];
   assign rd       = ir[11:7];
   assign pc_plus4 = pc + XLEN'(4);

   function automatic logic reg_ok(input logic [4:0] idx);
      return (idx != 5'd0) && (int'(idx) < NR);
   endfunction

   assign rf_a = reg_ok(rs1) ? rf[rs1] : '0;
   assign rf_b = reg_ok(rs2) ? rf[rs2] : '0;

   always_comb begin
      imm32 = '0;
      case (imm_src)
         3'b000:  imm32 = {{20{ir[31]}}, ir[31:20]};
         3'b001:  imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         3'b010:  imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         3'b011:  imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         3'b100:  imm32 = {ir[31:12], 12'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm_ext = XLEN'($signed(imm32));
   assign src_b   = alu_src ? imm : b;

   always_comb begin
      alu_res = a + src_b;
      case (alu_ctrl)
         3'b001:  alu_res = a - src_b;
         3'b010:  alu_res = a & src_b;
         3'b011:  alu_res = a | src_b;
         3'b101:  alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(src_b))};
         default: alu_res = a + src_b;
      endcase
   end

   assign u_res = is_lui ? imm : (pc + imm);

   always_comb begin
      wb_res = alu_q;
      case (result_src)
         2'b01:   wb_res = mdr;
         2'b10:   wb_res = pc_plus4;
         2'b11:   wb_res = u_res;
         default: wb_res = alu_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur <= S_FETCH;
      end else begin
         cur <= nxt;
      end
   end

   // MEMDONE is the cycle after a data access completes: stores retire there, loads move on to WB.
   always_comb begin
      nxt        = cur;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      retire     = 1'b0;
      case (cur)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (bus.imem_ready) nxt = S_DECODE;
         end
         S_DECODE: nxt = S_EXEC;
         S_EXEC:   nxt = (mem_write || is_load) ? S_MEM : S_WB;
         S_MEM: begin
            dmem_req_c = 1'b1;
            if (bus.dmem_ready) nxt = S_MEMDONE;
         end
         S_MEMDONE: begin
            if (is_load) begin
               nxt = S_WB;
            end else begin
               retire = 1'b1;
               nxt    = S_FETCH;
            end
         end
         S_WB: begin
            retire = 1'b1;
            nxt    = S_FETCH;
         end
         default: nxt = S_FETCH;
      endcase
   end

   assign state          = cur;
   assign bus.imem_req   = imem_req_c;
   assign bus.imem_addr  = pc;
   assign bus.dmem_req   = dmem_req_c;
   assign bus.dmem_we    = dmem_req_c & mem_write;
   assign bus.dmem_addr  = alu_q;
   assign bus.dmem_wdata = b;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= RESET_PC;
         pc_next <= '0;
         ir      <= '0;
         a       <= '0;
         b       <= '0;
         imm     <= '0;
         alu_q   <= '0;
         mdr     <= '0;
         zero    <= 1'b0;
      end else begin
         case (cur)
            S_FETCH: begin
               if (bus.imem_ready) ir <= bus.imem_rdata;
            end
            S_DECODE: begin
               a   <= rf_a;
               b   <= rf_b;
               imm <= imm_ext;
            end
            S_EXEC: begin
               alu_q   <= alu_res;
               zero    <= (alu_res == '0);
               pc_next <= pc_src ? (pc + imm) : pc_plus4;
            end
            S_MEM: begin
               if (bus.dmem_ready && is_load) mdr <= bus.dmem_rdata;
            end
            S_MEMDONE: begin
               if (!is_load) pc <= pc_next;
            end
            S_WB: pc <= pc_next;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) rf[i] <= '0;
      end else if (cur == S_WB && reg_write && reg_ok(rd)) begin
         rf[rd] <= wb_res;
      end
   end

`ifdef DP_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 64'd1;
         if (retire) instret_cnt <= instret_cnt + 64'd1;
      end
   end
`endif

endmodule
